// File: rtl/aquarium_sensor_bank_if.sv
// Report stream bundle for aquarium_sensor_bank: start request, valid/ready
// word handshake and the engine status flags.
interface aquarium_sensor_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int CW = $clog2(NUM_CH);

  logic             rpt_start;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CW-1:0]    rpt_ch;
  logic [WIDTH-1:0] rpt_data;
  logic             rpt_alarm;
  logic             rpt_busy;
  logic             rpt_done;

  // Report producer side (the sensor bank).
  modport master (
    input  rpt_start, rpt_ready,
    output rpt_valid, rpt_ch, rpt_data, rpt_alarm, rpt_busy, rpt_done
  );

  // Report consumer side (controller / display).
  modport slave (
    output rpt_start, rpt_ready,
    input  rpt_valid, rpt_ch, rpt_data, rpt_alarm, rpt_busy, rpt_done
  );
endinterface

// File: rtl/aquarium_sensor_bank.sv
// Tank sensor register bank: per-channel sample capture, low/high threshold
// range check with a persistence-filtered alarm, and a snapshot report engine
// that streams every channel value over a valid/ready handshake.
module aquarium_sensor_bank #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int PERSIST = 3
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         wr_en,
  input  logic [NUM_CH*WIDTH-1:0]   wr_data,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_hi,
  input  logic [WIDTH-1:0]          cfg_data,
  output logic [NUM_CH*WIDTH-1:0]   q,
  output logic [NUM_CH-1:0]         alarm,
  aquarium_sensor_bank_if.master    rpt
);
  localparam int             CW        = $clog2(NUM_CH);
  localparam logic [3:0]     PERSIST_C = 4'(PERSIST);
  localparam logic [CW-1:0]  LAST_CH   = CW'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} rpt_state_e;

  logic [NUM_CH-1:0][WIDTH-1:0] q_q,          q_d;
  logic [NUM_CH-1:0]            alarm_q,      alarm_d;
  logic [NUM_CH-1:0][3:0]       cnt_q,        cnt_d;
  logic [NUM_CH-1:0][WIDTH-1:0] lo_q,         lo_d;
  logic [NUM_CH-1:0][WIDTH-1:0] hi_q,         hi_d;
  logic [NUM_CH-1:0][WIDTH-1:0] snap_data_q,  snap_data_d;
  logic [NUM_CH-1:0]            snap_alarm_q, snap_alarm_d;
  rpt_state_e                   state_q,      state_d;
  logic [CW-1:0]                rpt_ch_q,     rpt_ch_d;
  logic [WIDTH-1:0]             rpt_data_q,   rpt_data_d;
  logic                         rpt_alarm_q,  rpt_alarm_d;
  logic                         rpt_done_q,   rpt_done_d;
  logic [CW-1:0]                rpt_ch_nxt;

  assign rpt_ch_nxt = rpt_ch_q + CW'(1);

  assign q              = q_q;
  assign alarm          = alarm_q;
  assign rpt.rpt_valid  = (state_q == SEND);
  assign rpt.rpt_busy   = (state_q == SEND);
  assign rpt.rpt_ch     = rpt_ch_q;
  assign rpt.rpt_data   = rpt_data_q;
  assign rpt.rpt_alarm  = rpt_alarm_q;
  assign rpt.rpt_done   = rpt_done_q;

  // Next-state logic: capture/range check, threshold writes and report FSM.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latches).
    q_d          = q_q;
    alarm_d      = alarm_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    snap_data_d  = snap_data_q;
    snap_alarm_d = snap_alarm_q;
    state_d      = state_q;
    rpt_ch_d     = rpt_ch_q;
    rpt_data_d   = rpt_data_q;
    rpt_alarm_d  = rpt_alarm_q;
    rpt_done_d   = 1'b0;

    // Capture uses the incoming sample against the pre-edge thresholds.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) begin
        q_d[i] = wr_data[i*WIDTH +: WIDTH];
        if ((wr_data[i*WIDTH +: WIDTH] < lo_q[i]) || (wr_data[i*WIDTH +: WIDTH] > hi_q[i])) begin
          if (cnt_q[i] != PERSIST_C) cnt_d[i] = cnt_q[i] + 4'd1;
          if (cnt_d[i] == PERSIST_C) alarm_d[i] = 1'b1;
        end else begin
          cnt_d[i]   = 4'd0;
          alarm_d[i] = 1'b0;
        end
      end
    end

    // Threshold writes; an out-of-range channel select matches no channel.
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CW'(i))) begin
        if (cfg_hi) hi_d[i] = cfg_data;
        else        lo_d[i] = cfg_data;
      end
    end

    // Report engine: word outputs are loaded one edge ahead so they are registered.
    case (state_q)
      IDLE: begin
        if (rpt.rpt_start) begin
          snap_data_d  = q_q;
          snap_alarm_d = alarm_q;
          rpt_ch_d     = '0;
          rpt_data_d   = q_q[0];
          rpt_alarm_d  = alarm_q[0];
          state_d      = SEND;
        end
      end
      SEND: begin
        if (rpt.rpt_ready) begin
          if (rpt_ch_q == LAST_CH) begin
            state_d     = IDLE;
            rpt_done_d  = 1'b1;
            rpt_ch_d    = '0;
            rpt_data_d  = '0;
            rpt_alarm_d = 1'b0;
          end else begin
            rpt_ch_d = rpt_ch_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
              if (rpt_ch_nxt == CW'(i)) begin
                rpt_data_d  = snap_data_q[i];
                rpt_alarm_d = snap_alarm_q[i];
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      q_q          <= '0;
      alarm_q      <= '0;
      cnt_q        <= '0;
      // NOTE: threshold and snapshot arrays are small flop banks, so they are reset like any other state.
      lo_q         <= '0;
      hi_q         <= '1;
      snap_data_q  <= '0;
      snap_alarm_q <= '0;
      state_q      <= IDLE;
      rpt_ch_q     <= '0;
      rpt_data_q   <= '0;
      rpt_alarm_q  <= 1'b0;
      rpt_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      q_q          <= q_d;
      alarm_q      <= alarm_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      snap_data_q  <= snap_data_d;
      snap_alarm_q <= snap_alarm_d;
      state_q      <= state_d;
      rpt_ch_q     <= rpt_ch_d;
      rpt_data_q   <= rpt_data_d;
      rpt_alarm_q  <= rpt_alarm_d;
      rpt_done_q   <= rpt_done_d;
    end
  end
endmodule

// File: tb/tb_aquarium_sensor_bank.sv
// Directed self-checking bench for aquarium_sensor_bank (4 channels x 8 bits).
module tb_aquarium_sensor_bank;
  logic        CLK = 1'b0;
  logic        reset_n;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_hi;
  logic [7:0]  cfg_data;
  logic [31:0] q;
  logic [3:0]  alarm;

  int total = 0;
  int bad   = 0;

  aquarium_sensor_bank_if #(.NUM_CH(4), .WIDTH(8)) rpt_bus ();

  aquarium_sensor_bank #(.NUM_CH(4), .WIDTH(8), .PERSIST(3)) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_hi   (cfg_hi),
    .cfg_data (cfg_data),
    .q        (q),
    .alarm    (alarm),
    .rpt      (rpt_bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int ch, input logic [7:0] val);
    wr_en             = 4'(1 << ch);
    wr_data           = '0;
    wr_data[ch*8 +: 8] = val;
    tick();
    wr_en = '0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic hi, input logic [7:0] val);
    cfg_we = 1'b1; cfg_ch = ch; cfg_hi = hi; cfg_data = val;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en = '0; wr_data = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_hi = 1'b0; cfg_data = '0;
    rpt_bus.rpt_start = 1'b0; rpt_bus.rpt_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (q !== 32'h0 || alarm !== 4'h0) begin
      bad++; $display("FAIL reset_q_alarm: got q=%h alarm=%b want q=0 alarm=0", q, alarm);
    end
    total++;
    if (rpt_bus.rpt_valid !== 1'b0 || rpt_bus.rpt_busy !== 1'b0 || rpt_bus.rpt_done !== 1'b0 ||
        rpt_bus.rpt_ch !== 2'd0 || rpt_bus.rpt_data !== 8'h0 || rpt_bus.rpt_alarm !== 1'b0) begin
      bad++; $display("FAIL reset_rpt: got v=%b b=%b d=%b ch=%0d data=%h al=%b want all 0",
        rpt_bus.rpt_valid, rpt_bus.rpt_busy, rpt_bus.rpt_done, rpt_bus.rpt_ch, rpt_bus.rpt_data, rpt_bus.rpt_alarm);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    wr_en = 4'b0101; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_en = '0;
    total++;
    if (q !== 32'h00FF_00FF) begin
      bad++; $display("FAIL capture_0101: got %h want %h", q, 32'h00FF_00FF);
    end
    wr_en = 4'b1010; wr_data = 32'h1122_3344;
    tick();
    wr_en = '0;
    total++;
    if (q !== 32'h11FF_33FF) begin
      bad++; $display("FAIL capture_1010: got %h want %h", q, 32'h11FF_33FF);
    end
  endtask

  task automatic test_alarm_persist();
    cfg(2'd1, 1'b0, 8'd20);
    cfg(2'd1, 1'b1, 8'd30);
    wr(1, 8'd35);
    wr(1, 8'd40);
    total++;
    if (alarm !== 4'b0000) begin
      bad++; $display("FAIL alarm_after_two: got %b want %b", alarm, 4'b0000);
    end
    wr(1, 8'd41);
    total++;
    if (alarm !== 4'b0010) begin
      bad++; $display("FAIL alarm_after_three: got %b want %b", alarm, 4'b0010);
    end
    wr(1, 8'd25);
    total++;
    if (alarm !== 4'b0000 || q[15:8] !== 8'd25) begin
      bad++; $display("FAIL alarm_clear: got alarm=%b q1=%0d want alarm=0000 q1=25", alarm, q[15:8]);
    end
  endtask

  task automatic test_boundary();
    cfg(2'd2, 1'b0, 8'd20);
    cfg(2'd2, 1'b1, 8'd30);
    wr(2, 8'd20);
    wr(2, 8'd30);
    wr(2, 8'd20);
    total++;
    if (alarm !== 4'b0000) begin
      bad++; $display("FAIL boundary_equal: got %b want %b", alarm, 4'b0000);
    end
    // Counter must still be 0: two out-of-range captures stay below PERSIST.
    wr(2, 8'd35);
    wr(2, 8'd35);
    total++;
    if (alarm !== 4'b0000) begin
      bad++; $display("FAIL boundary_counter_zero: got %b want %b", alarm, 4'b0000);
    end
    wr(2, 8'd25);
    cfg(2'd2, 1'b0, 8'd50);
    cfg(2'd2, 1'b1, 8'd10);
    wr(2, 8'd40);
    wr(2, 8'd40);
    total++;
    if (alarm !== 4'b0000) begin
      bad++; $display("FAIL inverted_two: got %b want %b", alarm, 4'b0000);
    end
    wr(2, 8'd40);
    total++;
    if (alarm !== 4'b0100) begin
      bad++; $display("FAIL inverted_three: got %b want %b", alarm, 4'b0100);
    end
    // Threshold writes alone must not re-evaluate the alarm.
    cfg(2'd2, 1'b0, 8'd0);
    cfg(2'd2, 1'b1, 8'd255);
    total++;
    if (alarm !== 4'b0100) begin
      bad++; $display("FAIL cfg_no_reeval: got %b want %b", alarm, 4'b0100);
    end
    wr(2, 8'd40);
    total++;
    if (alarm !== 4'b0000) begin
      bad++; $display("FAIL inrange_clear: got %b want %b", alarm, 4'b0000);
    end
  endtask

  task automatic test_report_backpressure();
    logic [7:0] exp_data [4];
    logic       exp_al   [4];
    int         done_cnt;
    exp_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_al   = '{1'b0, 1'b1, 1'b0, 1'b1};
    done_cnt = 0;
    // ch1 (lo=20) and ch3 (hi=2) go out of range on every capture below.
    cfg(2'd3, 1'b1, 8'd2);
    for (int k = 0; k < 3; k++) begin
      wr_en = 4'b1111; wr_data = 32'h0403_0201;
      tick();
    end
    wr_en = '0;
    total++;
    if (q !== 32'h0403_0201 || alarm !== 4'b1010) begin
      bad++; $display("FAIL rpt_setup: got q=%h alarm=%b want q=04030201 alarm=1010", q, alarm);
    end
    rpt_bus.rpt_start = 1'b1;
    tick();
    rpt_bus.rpt_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      total++;
      if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_busy !== 1'b1 || rpt_bus.rpt_ch !== 2'(w) ||
          rpt_bus.rpt_data !== exp_data[w] || rpt_bus.rpt_alarm !== exp_al[w]) begin
        bad++; $display("FAIL rpt_word%0d: got v=%b ch=%0d data=%h al=%b want v=1 ch=%0d data=%h al=%b",
          w, rpt_bus.rpt_valid, rpt_bus.rpt_ch, rpt_bus.rpt_data, rpt_bus.rpt_alarm, w, exp_data[w], exp_al[w]);
      end
      rpt_bus.rpt_ready = 1'b0;
      if (w == 0) begin
        wr_en = 4'b0001; wr_data = 32'h0000_00AA;
      end
      tick();
      wr_en = '0;
      if (rpt_bus.rpt_done === 1'b1) done_cnt++;
      total++;
      if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ch !== 2'(w) ||
          rpt_bus.rpt_data !== exp_data[w] || rpt_bus.rpt_alarm !== exp_al[w]) begin
        bad++; $display("FAIL rpt_stall%0d: got v=%b ch=%0d data=%h al=%b want v=1 ch=%0d data=%h al=%b",
          w, rpt_bus.rpt_valid, rpt_bus.rpt_ch, rpt_bus.rpt_data, rpt_bus.rpt_alarm, w, exp_data[w], exp_al[w]);
      end
      rpt_bus.rpt_ready = 1'b1;
      tick();
      rpt_bus.rpt_ready = 1'b0;
      if (rpt_bus.rpt_done === 1'b1) done_cnt++;
    end
    total++;
    if (rpt_bus.rpt_done !== 1'b1 || rpt_bus.rpt_valid !== 1'b0 || rpt_bus.rpt_busy !== 1'b0) begin
      bad++; $display("FAIL rpt_end: got done=%b v=%b busy=%b want done=1 v=0 busy=0",
        rpt_bus.rpt_done, rpt_bus.rpt_valid, rpt_bus.rpt_busy);
    end
    tick();
    if (rpt_bus.rpt_done === 1'b1) done_cnt++;
    total++;
    if (done_cnt != 1 || q[7:0] !== 8'hAA) begin
      bad++; $display("FAIL rpt_done_once: got pulses=%0d q0=%h want pulses=1 q0=aa", done_cnt, q[7:0]);
    end
  endtask

  task automatic test_start_handling();
    logic [7:0] exp_data [4];
    exp_data = '{8'hAA, 8'h02, 8'h03, 8'h04};
    rpt_bus.rpt_ready = 1'b1;
    rpt_bus.rpt_start = 1'b1;
    tick();
    rpt_bus.rpt_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      total++;
      if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ch !== 2'(w) || rpt_bus.rpt_data !== exp_data[w]) begin
        bad++; $display("FAIL start_word%0d: got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
          w, rpt_bus.rpt_valid, rpt_bus.rpt_ch, rpt_bus.rpt_data, w, exp_data[w]);
      end
      rpt_bus.rpt_start = (w == 1);
      tick();
      rpt_bus.rpt_start = 1'b0;
    end
    total++;
    if (rpt_bus.rpt_done !== 1'b1 || rpt_bus.rpt_valid !== 1'b0) begin
      bad++; $display("FAIL start_ignored: got done=%b v=%b want done=1 v=0",
        rpt_bus.rpt_done, rpt_bus.rpt_valid);
    end
    rpt_bus.rpt_start = 1'b1;
    tick();
    rpt_bus.rpt_start = 1'b0;
    total++;
    if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ch !== 2'd0 || rpt_bus.rpt_done !== 1'b0 ||
        rpt_bus.rpt_data !== 8'hAA) begin
      bad++; $display("FAIL start_on_done: got v=%b ch=%0d done=%b data=%h want v=1 ch=0 done=0 data=aa",
        rpt_bus.rpt_valid, rpt_bus.rpt_ch, rpt_bus.rpt_done, rpt_bus.rpt_data);
    end
    repeat (4) tick();
    total++;
    if (rpt_bus.rpt_done !== 1'b1 || rpt_bus.rpt_busy !== 1'b0) begin
      bad++; $display("FAIL start_second_end: got done=%b busy=%b want done=1 busy=0",
        rpt_bus.rpt_done, rpt_bus.rpt_busy);
    end
    rpt_bus.rpt_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int done_cnt;
    done_cnt = 0;
    rpt_bus.rpt_start = 1'b1;
    tick();
    rpt_bus.rpt_start = 1'b0;
    total++;
    if (rpt_bus.rpt_valid !== 1'b1) begin
      bad++; $display("FAIL areset_pre: got v=%b want v=1", rpt_bus.rpt_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (q !== 32'h0 || alarm !== 4'h0 || rpt_bus.rpt_valid !== 1'b0 || rpt_bus.rpt_busy !== 1'b0 ||
        rpt_bus.rpt_done !== 1'b0 || rpt_bus.rpt_ch !== 2'd0 || rpt_bus.rpt_data !== 8'h0) begin
      bad++; $display("FAIL areset_now: got q=%h al=%b v=%b b=%b d=%b ch=%0d data=%h want all 0",
        q, alarm, rpt_bus.rpt_valid, rpt_bus.rpt_busy, rpt_bus.rpt_done, rpt_bus.rpt_ch, rpt_bus.rpt_data);
    end
    reset_n = 1'b1;
    tick();
    if (rpt_bus.rpt_done === 1'b1) done_cnt++;
    rpt_bus.rpt_ready = 1'b1;
    rpt_bus.rpt_start = 1'b1;
    tick();
    rpt_bus.rpt_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      total++;
      if (rpt_bus.rpt_valid !== 1'b1 || rpt_bus.rpt_ch !== 2'(w) || rpt_bus.rpt_data !== 8'h0 ||
          rpt_bus.rpt_alarm !== 1'b0) begin
        bad++; $display("FAIL areset_word%0d: got v=%b ch=%0d data=%h al=%b want v=1 ch=%0d data=00 al=0",
          w, rpt_bus.rpt_valid, rpt_bus.rpt_ch, rpt_bus.rpt_data, rpt_bus.rpt_alarm, w);
      end
      if (rpt_bus.rpt_done === 1'b1) done_cnt++;
      tick();
    end
    rpt_bus.rpt_ready = 1'b0;
    total++;
    if (rpt_bus.rpt_done !== 1'b1 || done_cnt != 0) begin
      bad++; $display("FAIL areset_done: got done=%b early_pulses=%0d want done=1 early_pulses=0",
        rpt_bus.rpt_done, done_cnt);
    end
    // Thresholds back to 0/FF: these captures are all in range.
    for (int k = 0; k < 3; k++) begin
      wr_en = 4'b1010; wr_data = 32'hFF00_0500;
      tick();
    end
    wr_en = '0;
    total++;
    if (alarm !== 4'b0000 || q !== 32'hFF00_0500) begin
      bad++; $display("FAIL areset_thresholds: got alarm=%b q=%h want alarm=0000 q=ff000500", alarm, q);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_alarm_persist();
    test_boundary();
    test_report_backpressure();
    test_start_handling();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
